// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module sync_fifo_flags #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2,
  parameter bit          FWFT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int unsigned Depth = 1 << ASIZE;
  localparam int unsigned LvlW  = ASIZE + 1;

  localparam logic [ASIZE:0] DepthLvl  = LvlW'(Depth);
  localparam logic [ASIZE:0] AfullLvl  = LvlW'(AFULL_TH);
  localparam logic [ASIZE:0] AemptyLvl = LvlW'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > Depth) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH > Depth - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DSIZE-1:0] mem [Depth];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] level_q, level_d;
  logic           wfull_q, rempty_q, afull_q, aempty_q;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           wr_ok, rd_ok;
  logic [ASIZE-1:0] waddr, raddr;

  assign wr_ok = wreq & ~wfull_q;
  assign rd_ok = rreq & ~rempty_q;
  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  always_comb begin
    wptr_d  = wptr_q + LvlW'(wr_ok);
    rptr_d  = rptr_q + LvlW'(rd_ok);
    level_d = level_q + LvlW'(wr_ok) - LvlW'(rd_ok);

    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wreq && wfull_q)  overflow_d  = 1'b1;
    if (rreq && rempty_q) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      wfull_q     <= (level_d == DepthLvl);
      rempty_q    <= (level_d == '0);
      afull_q     <= (level_d >= AfullLvl);
      aempty_q    <= (level_d <= AemptyLvl);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata = mem[raddr];
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_ok) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one FWFT and one registered-read instance, with a
// data scoreboard per instance and directed flag checks.
module tb_sync_fifo_flags;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 4;

  logic clk;
  logic rst_n;

  // FWFT instance
  logic             wreq, rreq, clr_err;
  logic [DSIZE-1:0] wdata, rdata;
  logic             wfull, rempty, afull, aempty, ovf, unf;
  logic [ASIZE:0]   level;

  // Registered-read instance
  logic             wreq_s, rreq_s, clr_err_s;
  logic [DSIZE-1:0] wdata_s, rdata_s;
  logic             wfull_s, rempty_s, afull_s, aempty_s, ovf_s, unf_s;
  logic [ASIZE:0]   level_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DSIZE-1:0] q_f[$];
  logic [DSIZE-1:0] q_s[$];
  logic [DSIZE-1:0] exp_s;
  bit               pend_s = 0;

  sync_fifo_flags #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1'b1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .wreq(wreq), .wdata(wdata), .rreq(rreq), .rdata(rdata),
    .wfull(wfull), .rempty(rempty), .almost_full(afull), .almost_empty(aempty),
    .level(level), .overflow(ovf), .underflow(unf), .clr_err(clr_err)
  );

  sync_fifo_flags #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1'b0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .wreq(wreq_s), .wdata(wdata_s), .rreq(rreq_s),
    .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .almost_full(afull_s),
    .almost_empty(aempty_s), .level(level_s), .overflow(ovf_s), .underflow(unf_s),
    .clr_err(clr_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wreq = 0; rreq = 0; clr_err = 0; wdata = '0;
    wreq_s = 0; rreq_s = 0; clr_err_s = 0; wdata_s = '0;
  endtask

  task automatic write_f(input logic [DSIZE-1:0] d);
    wreq = 1; wdata = d; step(); wreq = 0;
  endtask

  task automatic drain_f(input int n);
    rreq = 1;
    for (int i = 0; i < n; i++) step();
    rreq = 0;
  endtask

  // Scoreboard monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_f.delete();
      q_s.delete();
      pend_s = 0;
    end else begin
      if (rreq && !rempty) begin
        if (q_f.size() == 0) check("fwft_sb_underrun", 32'd1, 32'd0);
        else check("fwft_rdata", 32'(rdata), 32'(q_f.pop_front()));
      end
      if (wreq && !wfull) q_f.push_back(wdata);

      if (pend_s) begin
        check("std_rdata", 32'(rdata_s), 32'(exp_s));
        pend_s = 0;
      end
      if (rreq_s && !rempty_s) begin
        if (q_s.size() == 0) check("std_sb_underrun", 32'd1, 32'd0);
        else begin
          exp_s  = q_s.pop_front();
          pend_s = 1;
        end
      end
      if (wreq_s && !wfull_s) q_s.push_back(wdata_s);
    end
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;

    // Reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_aempty", 32'(aempty), 32'd1);
    check("rst_afull", 32'(afull), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);
    check("rst_std_rdata", 32'(rdata_s), 32'd0);

    // 1: fill to 16, thresholds, overflow on 17th write
    for (int i = 1; i <= 16; i++) begin
      write_f(DSIZE'(i));
      check("fill_level", 32'(level), 32'(i));
      check("fill_afull", 32'(afull), 32'(i >= 12));
      check("fill_aempty", 32'(aempty), 32'(i <= 2));
      check("fill_wfull", 32'(wfull), 32'(i == 16));
      check("fill_rempty", 32'(rempty), 32'd0);
    end
    write_f(8'h99);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    drain_f(16);
    check("drain_rempty", 32'(rempty), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("drain_unf", 32'(unf), 32'd0);
    clr_err = 1; step(); clr_err = 0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // 2: FWFT single word, underflow, clr_err vs new error
    write_f(8'hA5);
    check("fwft_rempty", 32'(rempty), 32'd0);
    check("fwft_head", 32'(rdata), 32'hA5);
    rreq = 1; step();
    check("fwft_pop_rempty", 32'(rempty), 32'd1);
    step();
    check("unf_set", 32'(unf), 32'd1);
    clr_err = 1; step();
    check("unf_set_wins", 32'(unf), 32'd1);
    rreq = 0; step(); clr_err = 0;
    check("unf_clr", 32'(unf), 32'd0);

    // 3: registered read, one-cycle latency
    wreq_s = 1; wdata_s = 8'h11; step();
    wdata_s = 8'h22; step();
    wreq_s = 0;
    rreq_s = 1; step();
    check("std_rd0", 32'(rdata_s), 32'h11);
    step();
    check("std_rd1", 32'(rdata_s), 32'h22);
    rreq_s = 0; step();
    check("std_hold", 32'(rdata_s), 32'h22);
    check("std_rempty", 32'(rempty_s), 32'd1);

    // 4: simultaneous requests on full and on empty
    for (int i = 0; i < 16; i++) write_f(DSIZE'(8'h40 + i));
    wreq = 1; rreq = 1; wdata = 8'hEE; step(); rreq = 0; wreq = 0;
    check("full_both_level", 32'(level), 32'd15);
    check("full_both_ovf", 32'(ovf), 32'd1);
    check("full_both_wfull", 32'(wfull), 32'd0);
    write_f(8'hEF);
    check("refill_level", 32'(level), 32'd16);
    drain_f(16);
    clr_err = 1; step(); clr_err = 0;
    wreq = 1; rreq = 1; wdata = 8'h77; step(); rreq = 0; wreq = 0;
    check("empty_both_level", 32'(level), 32'd1);
    check("empty_both_unf", 32'(unf), 32'd1);
    drain_f(1);
    clr_err = 1; step(); clr_err = 0;

    // 5: stream 40 words at constant level 5 across pointer wrap
    for (int i = 0; i < 5; i++) write_f(DSIZE'(8'h80 + i));
    wreq = 1; rreq = 1;
    for (int i = 0; i < 40; i++) begin
      wdata = DSIZE'(8'h85 + i);
      step();
      check("stream_level", 32'(level), 32'd5);
    end
    wreq = 0; rreq = 0;
    check("stream_ovf", 32'(ovf), 32'd0);
    check("stream_unf", 32'(unf), 32'd0);
    drain_f(5);

    // 6: asynchronous reset with level 9
    for (int i = 0; i < 9; i++) write_f(DSIZE'(8'hC0 + i));
    check("pre_rst_level", 32'(level), 32'd9);
    #2 rst_n = 0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_rempty", 32'(rempty), 32'd1);
    check("arst_aempty", 32'(aempty), 32'd1);
    check("arst_afull", 32'(afull), 32'd0);
    step(); step();
    rst_n = 1;
    write_f(8'h3C);
    check("post_rst_head", 32'(rdata), 32'h3C);
    drain_f(1);
    check("post_rst_level", 32'(level), 32'd0);

    step(); step();
    check("sb_fwft_empty", 32'(q_f.size()), 32'd0);
    check("sb_std_empty", 32'(q_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
